// File: rtl/pmem_responder_if.sv
// pmem_responder_if: wishbone-style line bus between a master and pmem_responder
interface pmem_responder_if;
  logic         cyc;
  logic         stb;
  logic         we;
  logic [11:0]  adr;
  logic [15:0]  sel;
  logic [127:0] dat_m;
  logic [127:0] dat_s;
  logic         ack;
  logic         rty;
  modport master(output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, rty);
  modport slave(input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, rty);
endinterface

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency 4096x128 line memory responder; PMEM_REFRESH_EN adds refresh windows that answer RTY
module pmem_responder #(
  parameter int DELAY = 10,
  parameter int REFRESH_PERIOD = 64,
  parameter int REFRESH_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  pmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic we_q;
  logic [11:0] adr_q;
  logic [15:0] sel_q;
  logic [127:0] dat_q, dat_s;
  logic [127:0] mem [4096];
  logic idle, req, refresh, commit, cur_we;
  logic [11:0] cur_adr;
  logic [15:0] cur_sel;
  logic [127:0] cur_dat;
  assign idle = state == IDLE;
  assign req = bus.cyc & bus.stb;
  assign cur_we = idle ? bus.we : we_q;
  assign cur_adr = idle ? bus.adr : adr_q;
  assign cur_sel = idle ? bus.sel : sel_q;
  assign cur_dat = idle ? bus.dat_m : dat_q;
  assign commit = !rst && state != RESP && state_n == RESP;
  assign bus.ack = state == RESP;
  assign bus.dat_s = dat_s;
`ifdef PMEM_REFRESH_EN
  localparam int RW = REFRESH_PERIOD > 1 ? $clog2(REFRESH_PERIOD) : 1;
  logic [RW-1:0] ref_cnt;
  logic rty;
  assign refresh = ref_cnt < RW'(REFRESH_CYCLES);
  assign bus.rty = rty;
  always_ff @(posedge clk) begin
    ref_cnt <= (rst || ref_cnt == RW'(REFRESH_PERIOD - 1)) ? '0 : ref_cnt + 1'b1;
    rty <= !rst && idle && req && refresh;
  end
`else
  assign refresh = 1'b0;
  assign bus.rty = 1'b0;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (req && !refresh) begin
        state_n = DELAY == 1 ? RESP : WAIT;
        cnt_n = 8'(DELAY - 1);
      end
      WAIT: begin
        cnt_n = bus.cyc ? cnt - 8'd1 : 8'd0;
        state_n = !bus.cyc ? IDLE : cnt == 8'd1 ? RESP : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    cnt <= rst ? '0 : cnt_n;
    dat_s <= rst ? '0 : (commit && !cur_we) ? mem[cur_adr] : dat_s;
    if (idle) begin
      we_q <= bus.we;
      adr_q <= bus.adr;
      sel_q <= bus.sel;
      dat_q <= bus.dat_m;
    end
  end
  always_ff @(posedge clk)
    if (commit && cur_we)
      for (int i = 0; i < 16; i++)
        if (cur_sel[i]) mem[cur_adr][8*i +: 8] <= cur_dat[8*i +: 8];
endmodule

// File: tb/tb_pmem_responder.sv
// tb_pmem_responder: directed checks of latency, byte enables, abort, reset and back-to-back transfers
module tb_pmem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  logic rty_seen = 1'b0;
  logic both_seen = 1'b0;
  localparam logic [127:0] K = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D10 = 128'hDEADBEEF00112233445566778899AABB;
  localparam logic [127:0] D20 = 128'h20202020CAFEF00D1234567876543210;
  localparam logic [127:0] D1 = 128'h11111111111111111111111111111111;
  localparam logic [127:0] D2 = 128'h2222222222222222AAAAAAAAAAAAAAAA;
  pmem_responder_if bus();
  pmem_responder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.rty) rty_seen = 1'b1;
    if (bus.ack && bus.rty) both_seen = 1'b1;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic idle_bus;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
    bus.we = 1'b0;
    bus.adr = '0;
    bus.sel = '0;
    bus.dat_m = '0;
  endtask
  task automatic sync_ref;
`ifdef PMEM_REFRESH_EN
    while (dut.ref_cnt < 6 || dut.ref_cnt > 20) @(negedge clk);
`endif
  endtask
  task automatic drive(input logic w, input logic [11:0] a, input logic [15:0] s, input logic [127:0] d);
    bus.cyc = 1'b1;
    bus.stb = 1'b1;
    bus.we = w;
    bus.adr = a;
    bus.sel = s;
    bus.dat_m = d;
  endtask
  task automatic xfer(input logic w, input logic [11:0] a, input logic [15:0] s, input logic [127:0] d,
                      output logic [127:0] r, output int lat);
    int k;
    k = 0;
    r = 'x;
    lat = -1;
    @(negedge clk);
    drive(w, a, s, d);
    for (int n = 0; n < 200 && lat < 0; n++) begin
      @(negedge clk);
      k++;
      if (bus.rty) k = 0;
      else if (bus.ack) begin
        lat = k;
        r = bus.dat_s;
      end else if (k == 2) begin
        bus.we = ~w;
        bus.adr = ~a;
        bus.sel = ~s;
        bus.dat_m = ~d;
      end
    end
    idle_bus();
    if (lat > 0) begin
      @(negedge clk);
      check("ack_single_cycle", bus.ack, 1'b0);
    end
  endtask
  task automatic abort_xfer(input logic w, input logic [11:0] a, input logic [15:0] s, input logic [127:0] d,
                            input int n, output int acks);
    sync_ref();
    acks = 0;
    drive(w, a, s, d);
    repeat (n + 1) begin
      @(negedge clk);
      acks += int'(bus.ack);
    end
    idle_bus();
    repeat (20) begin
      @(negedge clk);
      acks += int'(bus.ack);
    end
  endtask
  initial begin
    logic [127:0] r, r1, r2;
    int lat, acks, t, t1, t2;
    idle_bus();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", bus.ack, 1'b0);
    check("rst_rty", bus.rty, 1'b0);
    check("rst_dat_s", bus.dat_s, '0);
    rst = 1'b0;
    xfer(1'b1, 12'h005, 16'hFFFF, K, r, lat);
    check("wr_latency", lat, 10);
    xfer(1'b0, 12'h005, 16'h0000, '0, r, lat);
    check("rd_latency", lat, 10);
    check("rd_data", r, K);
    xfer(1'b1, 12'h007, 16'hFFFF, '0, r, lat);
    xfer(1'b1, 12'h007, 16'h0001, {{15{8'hFF}}, 8'hAB}, r, lat);
    xfer(1'b0, 12'h007, 16'h0000, '0, r, lat);
    check("sel_byte0", r, 128'h000000000000000000000000000000AB);
    xfer(1'b1, 12'h007, 16'h8000, {8'h5A, {15{8'h11}}}, r, lat);
    xfer(1'b0, 12'h007, 16'h0000, '0, r, lat);
    check("sel_byte15", r, 128'h5A0000000000000000000000000000AB);
    xfer(1'b1, 12'h007, 16'h0000, '1, r, lat);
    check("sel0_latency", lat, 10);
    xfer(1'b0, 12'h007, 16'h0000, '0, r, lat);
    check("sel0_nochange", r, 128'h5A0000000000000000000000000000AB);
    xfer(1'b1, 12'h010, 16'hFFFF, D10, r, lat);
    abort_xfer(1'b0, 12'h010, 16'h0000, '0, 3, acks);
    check("abort_rd_noack", acks, 0);
    xfer(1'b0, 12'h010, 16'h0000, '0, r, lat);
    check("after_abort_latency", lat, 10);
    check("after_abort_data", r, D10);
    abort_xfer(1'b1, 12'h010, 16'hFFFF, ~D10, 3, acks);
    check("abort_wr_noack", acks, 0);
    xfer(1'b0, 12'h010, 16'h0000, '0, r, lat);
    check("abort_wr_nochange", r, D10);
    xfer(1'b1, 12'h020, 16'hFFFF, D20, r, lat);
    xfer(1'b0, 12'h020, 16'h0000, '0, r, lat);
    check("pre_rst_data", r, D20);
    sync_ref();
    drive(1'b1, 12'h020, 16'hFFFF, ~D20);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle_bus();
    @(negedge clk);
    check("midwait_rst_dat_s", bus.dat_s, '0);
    check("midwait_rst_ack", bus.ack, 1'b0);
    rst = 1'b0;
    acks = 0;
    repeat (15) begin
      @(negedge clk);
      acks += int'(bus.ack);
    end
    check("midwait_rst_noack", acks, 0);
    xfer(1'b0, 12'h020, 16'h0000, '0, r, lat);
    check("midwait_rst_latency", lat, 10);
    check("midwait_rst_nochange", r, D20);
    xfer(1'b1, 12'h001, 16'hFFFF, D1, r, lat);
    xfer(1'b1, 12'h002, 16'hFFFF, D2, r, lat);
    sync_ref();
    drive(1'b0, 12'h001, 16'h0000, '0);
    t = 0;
    t1 = -1;
    t2 = -1;
    r1 = 'x;
    r2 = 'x;
    for (int n = 0; n < 60 && t2 < 0; n++) begin
      @(negedge clk);
      t++;
      if (bus.ack && t1 < 0) begin
        t1 = t;
        r1 = bus.dat_s;
        bus.adr = 12'h002;
      end else if (bus.ack) begin
        t2 = t;
        r2 = bus.dat_s;
      end
    end
    idle_bus();
    check("b2b_first_latency", t1, 10);
    check("b2b_gap", t2 - t1, 11);
    check("b2b_data1", r1, D1);
    check("b2b_data2", r2, D2);
`ifdef PMEM_REFRESH_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 12'h005, 16'h0000, '0);
    @(negedge clk);
    check("refresh_rty", bus.rty, 1'b1);
    check("refresh_noack", bus.ack, 1'b0);
    idle_bus();
    @(negedge clk);
    check("refresh_rty_pulse", bus.rty, 1'b0);
    xfer(1'b0, 12'h005, 16'h0000, '0, r, lat);
    check("refresh_retry_latency", lat, 10);
    check("refresh_retry_data", r, K);
`else
    check("rty_never", rty_seen, 1'b0);
`endif
    check("ack_rty_exclusive", both_seen, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
